connect4_win_checker: RTL

// - Check engine driven by the top game FSM while it is in its CHECK state (check_en=1, row_addr_sel=4).
// - Reads the 6x7 board row by row from the board memory into a local buffer.
// - Scans the 4 line directions through the last dropped piece.
// - Reports check_4 (win) or check_finish (no win); the top FSM then moves to GAME_OVER or WAIT_RELEASE.

---
 rtl/connect4_pkg.sv | 56 +++++
 rtl/connect4_win_checker_line_eval.sv | 45 ++++
 rtl/connect4_win_checker.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/connect4_pkg.sv
// Shared constants, types and helpers for the Connect-4 win checker.
// Holds board geometry, cell codes, FSM states and line directions.
package connect4_pkg;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int CELL_W  = 2;
  localparam int WIN_LEN = 4;
  localparam int ROW_W   = COLS * CELL_W;
  localparam int BOARD_W = ROWS * ROW_W;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
  localparam logic [CELL_W-1:0] CELL_P1    = 2'b01;
  localparam logic [CELL_W-1:0] CELL_P2    = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_e;

  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_UR, DIR_UL} dir_e;

  typedef logic [ROWS-1:0][ROW_W-1:0] board_t;

  function automatic int dir_drow(dir_e d);
    return (d == DIR_H) ? 0 : 1;
  endfunction

  function automatic int dir_dcol(dir_e d);
    case (d)
      DIR_H:   return 1;
      DIR_V:   return 0;
      DIR_UR:  return 1;
      default: return -1;
    endcase
  endfunction

  // Callers must keep r below ROWS and c below COLS.
  function automatic logic [CELL_W-1:0] cell_at(board_t b, logic [2:0] r, logic [2:0] c);
    logic [ROW_W-1:0] bits;
    bits = b[r] >> {c, 1'b0};
    return bits[CELL_W-1:0];
  endfunction

  function automatic logic is_player(logic [CELL_W-1:0] v);
    return (v == CELL_P1) || (v == CELL_P2);
  endfunction

  // The illegal code 11 counts as empty, so only real pieces fill a row.
  function automatic logic row_full(logic [ROW_W-1:0] row);
    logic full;
    full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (!is_player(row[c*CELL_W +: CELL_W])) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/connect4_win_checker_line_eval.sv
// Combinational run counter for one direction through a board position.
// Returns 1 + same-piece runs on both sides, each side capped at WIN_LEN-1.
module c4_line_eval
  import connect4_pkg::*;
(
  input  logic [BOARD_W-1:0] board_i,
  input  logic [2:0]         row_i,
  input  logic [2:0]         col_i,
  input  logic [1:0]         dir_i,
  input  logic [CELL_W-1:0]  p_i,
  output logic [2:0]         count_o
);

  board_t board;
  assign board = board_i;

  always_comb begin
    int   dr;
    int   dc;
    int   r;
    int   c;
    int   sgn;
    logic run;
    count_o = 3'd1;
    dr      = dir_drow(dir_e'(dir_i));
    dc      = dir_dcol(dir_e'(dir_i));
    r       = 0;
    c       = 0;
    sgn     = 1;
    run     = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sgn = (s == 0) ? 1 : -1;
      run = 1'b1;
      for (int k = 1; k < WIN_LEN; k++) begin
        r = int'(row_i) + sgn * k * dr;
        c = int'(col_i) + sgn * k * dc;
        // A run ends at the board edge; coordinates never wrap to the next row.
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) run = 1'b0;
        else if (cell_at(board, r[2:0], c[2:0]) != p_i) run = 1'b0;
        if (run) count_o = count_o + 3'd1;
      end
    end
  end

endmodule

// File: rtl/connect4_win_checker.sv
// Connect-4 check engine: loads the board row by row, then scans the four
// line directions through the last dropped piece and reports win / no win.
module connect4_win_checker
  import connect4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             check_en,
  input  logic [2:0]       last_row,
  input  logic [2:0]       last_col,
  output logic [2:0]       row_addr,
  input  logic [ROW_W-1:0] row_data,
  output logic             check_finish,
  output logic             check_4,
  output logic [1:0]       winner,
  output logic             board_full
);

  localparam logic [2:0] ROWS_L    = 3'(ROWS);
  localparam logic [2:0] COLS_L    = 3'(COLS);
  localparam logic [2:0] LAST_ADDR = 3'(ROWS - 1);
  localparam logic [2:0] WIN_L     = 3'(WIN_LEN);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  dir_e        dir_q, dir_d;
  logic [2:0]  lrow_q, lrow_d;
  logic [2:0]  lcol_q, lcol_d;
  board_t      buf_q, buf_d;
  logic [2:0]  row_addr_q, row_addr_d;
  logic        finish_q, finish_d;
  logic        win_q, win_d;
  logic [1:0]  winner_q, winner_d;
  logic        full_q, full_d;

  logic [CELL_W-1:0] p_cell;
  logic              p_valid;
  logic [2:0]        eval_count;
  logic              win_hit;

  // An off-board capture reads as empty so it can never produce a win.
  assign p_cell  = (lrow_q < ROWS_L && lcol_q < COLS_L) ? cell_at(buf_q, lrow_q, lcol_q)
                                                        : CELL_EMPTY;
  assign p_valid = is_player(p_cell);
  assign win_hit = p_valid && (eval_count >= WIN_L);

  c4_line_eval u_line_eval (
    .board_i (buf_q),
    .row_i   (lrow_q),
    .col_i   (lcol_q),
    .dir_i   (dir_q),
    .p_i     (p_cell),
    .count_o (eval_count)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    lrow_d     = lrow_q;
    lcol_d     = lcol_q;
    buf_d      = buf_q;
    row_addr_d = row_addr_q;
    finish_d   = finish_q;
    win_d      = win_q;
    winner_d   = winner_q;
    full_d     = full_q;
    unique case (state_q)
      IDLE: begin
        row_addr_d = '0;
        if (check_en) begin
          lrow_d  = last_row;
          lcol_d  = last_col;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!check_en) begin
          row_addr_d = '0;
          state_d    = IDLE;
        end else begin
          // Memory data trails its address by one cycle, so slot cnt-1 is filled.
          if (cnt_q != 3'd0) buf_d[cnt_q - 3'd1] = row_data;
          row_addr_d = (cnt_q < LAST_ADDR) ? cnt_q + 3'd1 : 3'd0;
          if (cnt_q == ROWS_L) begin
            dir_d   = DIR_H;
            state_d = EVAL;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      EVAL: begin
        if (!check_en) begin
          state_d = IDLE;
        end else if (win_hit) begin
          finish_d = 1'b1;
          win_d    = 1'b1;
          winner_d = p_cell;
          full_d   = row_full(buf_q[ROWS-1]);
          state_d  = DONE;
        end else if (dir_q == DIR_UL) begin
          finish_d = 1'b1;
          full_d   = row_full(buf_q[ROWS-1]);
          state_d  = DONE;
        end else begin
          dir_d = dir_e'(dir_q + 2'd1);
        end
      end
      DONE: begin
        if (!check_en) begin
          finish_d = 1'b0;
          win_d    = 1'b0;
          winner_d = CELL_EMPTY;
          full_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dir_q      <= DIR_H;
      lrow_q     <= '0;
      lcol_q     <= '0;
      buf_q      <= '0;
      row_addr_q <= '0;
      finish_q   <= 1'b0;
      win_q      <= 1'b0;
      winner_q   <= CELL_EMPTY;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      lrow_q     <= lrow_d;
      lcol_q     <= lcol_d;
      buf_q      <= buf_d;
      row_addr_q <= row_addr_d;
      finish_q   <= finish_d;
      win_q      <= win_d;
      winner_q   <= winner_d;
      full_q     <= full_d;
    end
  end

  assign row_addr     = row_addr_q;
  assign check_finish = finish_q;
  assign check_4      = win_q;
  assign winner       = winner_q;
  assign board_full   = full_q;

endmodule
